// File: rtl/dvp_capture_win_if.sv
// DVP capture bus: sensor pins and window configuration in, pixel stream out.
`timescale 1ns/1ps
interface dvp_capture_win_if #(
    parameter int unsigned DW  = 8,
    parameter int unsigned BPP = 2,
    parameter int unsigned XW  = 12,
    parameter int unsigned YW  = 12
);
    logic              Vsync;
    logic              Href;
    logic [DW-1:0]     Data;
    logic              Enable;
    logic [XW-1:0]     WinX0;
    logic [YW-1:0]     WinY0;
    logic [XW-1:0]     WinW;
    logic [YW-1:0]     WinH;
    logic              ImageState;
    logic              DataValid;
    logic [DW*BPP-1:0] DataPixel;
    logic              DataHs;
    logic              DataVs;
    logic [XW-1:0]     Xaddr;
    logic [YW-1:0]     Yaddr;
    logic              FrameDone;
    logic              PartialErr;

    // Capture block side
    modport slave (
        input  Vsync, Href, Data, Enable, WinX0, WinY0, WinW, WinH,
        output ImageState, DataValid, DataPixel, DataHs, DataVs,
               Xaddr, Yaddr, FrameDone, PartialErr
    );

    // Sensor / configuration side
    modport master (
        output Vsync, Href, Data, Enable, WinX0, WinY0, WinW, WinH,
        input  ImageState, DataValid, DataPixel, DataHs, DataVs,
               Xaddr, Yaddr, FrameDone, PartialErr
    );
endinterface

// File: rtl/dvp_capture_win.sv
// DVP capture front end: beat-to-pixel assembly, frame skipping after enable,
// runtime crop window and window-relative coordinates.
`timescale 1ns/1ps
module dvp_capture_win #(
    parameter int unsigned DW          = 8,
    parameter int unsigned BPP         = 2,
    parameter int unsigned SKIP_FRAMES = 10,
    parameter int unsigned XW          = 12,
    parameter int unsigned YW          = 12,
    parameter bit          VSYNC_POL   = 1'b1
) (
    input logic              PCLK,
    input logic              Rst_p,
    dvp_capture_win_if.slave bus
);
    localparam int unsigned PW  = DW * BPP;
    localparam int unsigned BW  = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int unsigned SKW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam logic [BW-1:0]  BEAT_LAST = BW'(BPP - 1);
    localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_RUN} state_e;

    state_e         state_q, state_d;
    logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
    logic           vsync_q, href_q, href_prev_q, blank_prev_q;
    logic [DW-1:0]  data_q;
    logic [BW-1:0]  beat_q, beat_d;
    logic [PW-1:0]  pix_buf_q, pix_buf_d, pix_asm_c;
    logic [XW-1:0]  px_q, px_d, x0_q, x0_d, w_q, w_d, xaddr_q, xaddr_d;
    logic [YW-1:0]  ly_q, ly_d, y0_q, y0_d, h_q, h_d, yaddr_q, yaddr_d;
    logic [PW-1:0]  pixel_q, pixel_d;
    logic           image_state_q, image_state_d, valid_q, valid_d;
    logic           hs_q, hs_d, vs_q, vs_d, frame_done_q, frame_done_d;
    logic           perr_q, perr_d, got_pix_q, got_pix_d;
    logic           blank_c, fs_c, le_c, run_c, complete_c, in_win_c;
    logic [XW:0]    x_end_c;
    logic [YW:0]    y_end_c;

    assign blank_c    = (vsync_q == VSYNC_POL);
    assign fs_c       = blank_c & ~blank_prev_q;
    assign le_c       = href_prev_q & ~href_q;
    assign run_c      = (state_q == ST_RUN);
    assign complete_c = href_q && (beat_q == BEAT_LAST);
    assign x_end_c    = {1'b0, x0_q} + {1'b0, w_q};
    assign y_end_c    = {1'b0, y0_q} + {1'b0, h_q};
    assign in_win_c   = (px_q >= x0_q) && ((w_q == '0) || ({1'b0, px_q} < x_end_c)) &&
                        (ly_q >= y0_q) && ((h_q == '0) || ({1'b0, ly_q} < y_end_c));

    // Capture state: idle, discarding frames after enable, or running
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Enable && fs_c) begin
                    skip_cnt_d = '0;
                    state_d    = (SKIP_FRAMES > 0) ? ST_SKIP : ST_RUN;
                end
            end
            ST_SKIP: begin
                if (!bus.Enable) begin
                    state_d = ST_IDLE;
                end else if (fs_c) begin
                    if (skip_cnt_q == SKIP_LAST) state_d = ST_RUN;
                    else skip_cnt_d = skip_cnt_q + SKW'(1);
                end
            end
            ST_RUN: begin
                if (fs_c && !bus.Enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat assembly, pixel/line counters, window test and output staging
    always_comb begin
        pix_asm_c = pix_buf_q;
        for (int k = 0; k < BPP; k++) begin
            if (beat_q == BW'(k)) pix_asm_c[DW*(BPP-k)-1 -: DW] = data_q;
        end
        beat_d        = '0;
        pix_buf_d     = pix_buf_q;
        px_d          = px_q;
        ly_d          = ly_q;
        x0_d          = x0_q;
        y0_d          = y0_q;
        w_d           = w_q;
        h_d           = h_q;
        pixel_d       = pixel_q;
        xaddr_d       = xaddr_q;
        yaddr_d       = yaddr_q;
        valid_d       = run_c & complete_c & in_win_c;
        hs_d          = run_c & href_q;
        vs_d          = run_c & ~blank_c;
        image_state_d = (state_d != ST_RUN);
        frame_done_d  = fs_c & run_c & got_pix_q;
        perr_d        = perr_q;
        got_pix_d     = got_pix_q | valid_d;
        if (href_q) begin
            pix_buf_d = pix_asm_c;
            beat_d    = complete_c ? '0 : beat_q + BW'(1);
        end
        if (complete_c) begin
            pixel_d = pix_asm_c;
            xaddr_d = px_q - x0_q;
            yaddr_d = ly_q - y0_q;
            if (px_q != '1) px_d = px_q + XW'(1);
        end
        if (le_c) begin
            px_d = '0;
            if (ly_q != '1) ly_d = ly_q + YW'(1);
            if (beat_q != '0) perr_d = 1'b1;
        end
        if (fs_c) begin
            px_d      = '0;
            ly_d      = '0;
            x0_d      = bus.WinX0;
            y0_d      = bus.WinY0;
            w_d       = bus.WinW;
            h_d       = bus.WinH;
            perr_d    = 1'b0;
            got_pix_d = 1'b0;
        end
    end

    // All state and registered outputs
    always_ff @(posedge PCLK) begin
        if (Rst_p) begin
            state_q       <= ST_IDLE;
            skip_cnt_q    <= '0;
            vsync_q       <= VSYNC_POL;
            blank_prev_q  <= 1'b1;
            href_q        <= 1'b0;
            href_prev_q   <= 1'b0;
            data_q        <= '0;
            beat_q        <= '0;
            pix_buf_q     <= '0;
            px_q          <= '0;
            ly_q          <= '0;
            x0_q          <= '0;
            y0_q          <= '0;
            w_q           <= '0;
            h_q           <= '0;
            pixel_q       <= '0;
            xaddr_q       <= '0;
            yaddr_q       <= '0;
            valid_q       <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            image_state_q <= 1'b1;
            frame_done_q  <= 1'b0;
            perr_q        <= 1'b0;
            got_pix_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            skip_cnt_q    <= skip_cnt_d;
            vsync_q       <= bus.Vsync;
            blank_prev_q  <= blank_c;
            href_q        <= bus.Href;
            href_prev_q   <= href_q;
            data_q        <= bus.Data;
            beat_q        <= beat_d;
            pix_buf_q     <= pix_buf_d;
            px_q          <= px_d;
            ly_q          <= ly_d;
            x0_q          <= x0_d;
            y0_q          <= y0_d;
            w_q           <= w_d;
            h_q           <= h_d;
            pixel_q       <= pixel_d;
            xaddr_q       <= xaddr_d;
            yaddr_q       <= yaddr_d;
            valid_q       <= valid_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            image_state_q <= image_state_d;
            frame_done_q  <= frame_done_d;
            perr_q        <= perr_d;
            got_pix_q     <= got_pix_d;
        end
    end

    assign bus.ImageState = image_state_q;
    assign bus.DataValid  = valid_q;
    assign bus.DataPixel  = pixel_q;
    assign bus.DataHs     = hs_q;
    assign bus.DataVs     = vs_q;
    assign bus.Xaddr      = xaddr_q;
    assign bus.Yaddr      = yaddr_q;
    assign bus.FrameDone  = frame_done_q;
    assign bus.PartialErr = perr_q;
endmodule

// File: tb/tb_dvp_capture_win.sv
// Bench for dvp_capture_win: frame-level reference model with random pixel data.
`timescale 1ns/1ps
module tb_dvp_capture_win;
    localparam int unsigned DW = 8, BPP = 2, SKIP = 2, XW = 12, YW = 12;
    localparam int unsigned PW = DW * BPP, EW = PW + XW + YW;

    logic PCLK = 1'b0;
    logic Rst_p;
    always #5 PCLK = ~PCLK;

    dvp_capture_win_if #(.DW(DW), .BPP(BPP), .XW(XW), .YW(YW)) bus ();
    dvp_capture_win #(.DW(DW), .BPP(BPP), .SKIP_FRAMES(SKIP), .XW(XW), .YW(YW),
                      .VSYNC_POL(1'b1)) dut (.PCLK(PCLK), .Rst_p(Rst_p), .bus(bus));

    int errors = 0, checks = 0;
    logic [EW-1:0] exp_q[$], got_q[$];
    int unsigned gcyc_q[$];
    int unsigned cyc = 0, first_beat_cyc = 0;
    int fd_cnt = 0, fd_exp = 0, hs_cnt = 0;
    int m_cnt = 0, m_cap_pix = 0, m_x0 = 0, m_y0 = 0, m_w = 0, m_h = 0;
    bit m_cap = 1'b0, m_perr = 1'b0;
    logic [DW-1:0] fixed_b [BPP];

    always @(posedge PCLK) cyc <= cyc + 1;

    // Output monitor
    always @(negedge PCLK) begin
        if (bus.DataValid === 1'b1) begin
            got_q.push_back({bus.DataPixel, bus.Xaddr, bus.Yaddr});
            gcyc_q.push_back(cyc);
        end
        if (bus.FrameDone === 1'b1) fd_cnt++;
        if (bus.DataHs === 1'b1) hs_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Frame boundary in the reference model: close previous frame, decide capture of the next
    function automatic void model_fs();
        if (m_cap && m_cap_pix > 0) fd_exp++;
        if (bus.Enable) m_cnt++;
        else m_cnt = 0;
        m_cap     = bus.Enable && (m_cnt > SKIP);
        m_cap_pix = 0;
        m_perr    = 1'b0;
        m_x0 = int'(bus.WinX0); m_y0 = int'(bus.WinY0);
        m_w  = int'(bus.WinW);  m_h  = int'(bus.WinH);
    endfunction

    function automatic void model_reset();
        m_cnt = 0; m_cap = 1'b0; m_cap_pix = 0; m_perr = 1'b0;
    endfunction

    // One frame: blanking pulse (frame start), then lines of beats with gaps
    task automatic drive_frame(input int nlines, input int npix, input int cut_line,
                               input int cut_beats, input int en_off_line,
                               input bit fixed_first, input bit scramble);
        logic [PW-1:0] acc;
        logic [DW-1:0] b;
        int nb, px;
        bus.Vsync = 1'b1;
        bus.Href  = 1'b0;
        model_fs();
        repeat (4) tick();
        bus.Vsync = 1'b0;
        repeat (3) tick();
        for (int ly = 0; ly < nlines; ly++) begin
            if (ly == en_off_line) bus.Enable = 1'b0;
            if (scramble && ly == 1) begin
                bus.WinX0 = XW'($urandom_range(0, 7)); bus.WinY0 = YW'($urandom_range(0, 7));
                bus.WinW  = XW'($urandom_range(0, 7)); bus.WinH  = YW'($urandom_range(0, 7));
            end
            nb  = (ly == cut_line) ? cut_beats : npix * int'(BPP);
            acc = '0;
            for (int k = 0; k < nb; k++) begin
                b = (fixed_first && ly == 0 && k < int'(BPP)) ? fixed_b[k] : DW'($urandom);
                bus.Href = 1'b1;
                bus.Data = b;
                if (ly == 0 && k == int'(BPP) - 1) first_beat_cyc = cyc;
                acc = (acc << DW) | PW'(b);
                if ((k % int'(BPP)) == int'(BPP) - 1) begin
                    px = k / int'(BPP);
                    if (m_cap && px >= m_x0 && (m_w == 0 || px < m_x0 + m_w) &&
                        ly >= m_y0 && (m_h == 0 || ly < m_y0 + m_h)) begin
                        exp_q.push_back({acc, XW'(px - m_x0), YW'(ly - m_y0)});
                        m_cap_pix++;
                    end
                    acc = '0;
                end
                tick();
            end
            if ((nb % int'(BPP)) != 0) m_perr = 1'b1;
            bus.Href = 1'b0;
            bus.Data = DW'($urandom);
            repeat (3) tick();
        end
        repeat (2) tick();
    endtask

    function automatic void clear_q();
        exp_q.delete(); got_q.delete(); gcyc_q.delete();
    endfunction

    task automatic test_reset();
        bus.Vsync = 1'b0; bus.Href = 1'b0; bus.Data = '0; bus.Enable = 1'b0;
        bus.WinX0 = '0; bus.WinY0 = '0; bus.WinW = '0; bus.WinH = '0;
        Rst_p = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.ImageState, bus.DataValid, bus.DataHs, bus.DataVs, bus.FrameDone, bus.PartialErr}
            !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 100000",
                {bus.ImageState, bus.DataValid, bus.DataHs, bus.DataVs, bus.FrameDone, bus.PartialErr});
        end
        checks++;
        if ({bus.DataPixel, bus.Xaddr, bus.Yaddr} !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {bus.DataPixel, bus.Xaddr, bus.Yaddr});
        end
        Rst_p = 1'b0;
        model_reset();
        repeat (2) tick();
    endtask

    task automatic test_skip();
        bus.Enable = 1'b1;
        for (int f = 0; f < 4; f++) begin
            clear_q();
            drive_frame(2, 4, -1, 0, -1, 1'b0, 1'b0);
            checks++;
            if (got_q.size() != ((f < 2) ? 0 : 8)) begin
                errors++;
                $display("FAIL skip_count f%0d: got %0d strobes expected %0d", f, got_q.size(), (f < 2) ? 0 : 8);
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL skip_pixel f%0d i%0d: got %h expected %h", f, i, got_q[i], exp_q[i]);
                end
            end
            checks++;
            if (bus.ImageState !== ((f < 2) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL skip_imagestate f%0d: got %b expected %b", f, bus.ImageState, f < 2);
            end
        end
        drive_frame(0, 0, -1, 0, -1, 1'b0, 1'b0);
        checks++;
        if (fd_cnt != fd_exp || fd_exp != 2) begin
            errors++;
            $display("FAIL skip_framedone: got %0d pulses expected %0d (model %0d)", fd_cnt, 2, fd_exp);
        end
    endtask

    task automatic test_latency();
        clear_q();
        drive_frame(1, 3, -1, 0, -1, 1'b1, 1'b0);
        checks++;
        if (got_q.size() == 0 || got_q[0] !== {16'hABCD, 12'd0, 12'd0}) begin
            errors++;
            $display("FAIL latency_pixel: got %h expected %h", (got_q.size() > 0) ? got_q[0] : '0,
                     {16'hABCD, 12'd0, 12'd0});
        end
        checks++;
        if (gcyc_q.size() == 0 || gcyc_q[0] != first_beat_cyc + 2) begin
            errors++;
            $display("FAIL latency_cycle: got %0d expected %0d", (gcyc_q.size() > 0) ? gcyc_q[0] : 0,
                     first_beat_cyc + 2);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL latency_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_window();
        clear_q();
        bus.WinX0 = 12'd1; bus.WinY0 = 12'd1; bus.WinW = 12'd2; bus.WinH = 12'd1;
        drive_frame(3, 4, -1, 0, -1, 1'b0, 1'b1);
        bus.WinX0 = '0; bus.WinY0 = '0; bus.WinW = '0; bus.WinH = '0;
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("FAIL window_count: got %0d strobes expected 2", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 2; i++) begin
            checks++;
            if (got_q[i][XW+YW-1:0] !== {XW'(i), YW'(0)}) begin
                errors++;
                $display("FAIL window_coord i%0d: got %h expected %h", i, got_q[i][XW+YW-1:0], {XW'(i), YW'(0)});
            end
            checks++;
            if (i < exp_q.size() && got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL window_pixel i%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int f = 0; f < 6; f++) begin
            bus.WinX0 = XW'($urandom_range(0, 3)); bus.WinY0 = YW'($urandom_range(0, 2));
            bus.WinW  = XW'($urandom_range(0, 4)); bus.WinH  = YW'($urandom_range(0, 3));
            drive_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), -1, 0, -1, 1'b0, 1'b1);
        end
        bus.WinX0 = '0; bus.WinY0 = '0; bus.WinW = '0; bus.WinH = '0;
        drive_frame(0, 0, -1, 0, -1, 1'b0, 1'b0);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_pixel i%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (fd_cnt != fd_exp) begin
            errors++;
            $display("FAIL random_framedone: got %0d expected %0d", fd_cnt, fd_exp);
        end
    endtask

    task automatic test_partial();
        clear_q();
        drive_frame(2, 3, 0, 3, -1, 1'b0, 1'b0);
        checks++;
        if (got_q.size() != 4 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL partial_count: got %0d expected 4 (model %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL partial_pixel i%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (bus.PartialErr !== m_perr || !m_perr) begin
            errors++;
            $display("FAIL partial_err_set: got %b expected 1", bus.PartialErr);
        end
        drive_frame(1, 2, -1, 0, -1, 1'b0, 1'b0);
        checks++;
        if (bus.PartialErr !== m_perr) begin
            errors++;
            $display("FAIL partial_err_clear: got %b expected %b", bus.PartialErr, m_perr);
        end
    endtask

    task automatic test_enable_drop();
        int fd0, hs0;
        clear_q();
        drive_frame(3, 3, -1, 0, 1, 1'b0, 1'b0);
        checks++;
        if (got_q.size() != 9 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL endrop_count: got %0d expected 9", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL endrop_pixel i%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        fd0 = fd_cnt;
        clear_q();
        drive_frame(2, 2, -1, 0, -1, 1'b0, 1'b0);
        hs0 = hs_cnt;
        drive_frame(2, 2, -1, 0, -1, 1'b0, 1'b0);
        checks++;
        if (fd_cnt - fd0 != 1 || fd_cnt != fd_exp) begin
            errors++;
            $display("FAIL endrop_framedone: got %0d pulses expected 1", fd_cnt - fd0);
        end
        checks++;
        if (bus.ImageState !== 1'b1) begin
            errors++;
            $display("FAIL endrop_imagestate: got %b expected 1", bus.ImageState);
        end
        checks++;
        if (got_q.size() != 0 || hs_cnt != hs0) begin
            errors++;
            $display("FAIL endrop_idle_out: got %0d strobes %0d hs expected 0 0", got_q.size(), hs_cnt - hs0);
        end
    endtask

    task automatic test_rst_midline();
        bus.Enable = 1'b1;
        for (int f = 0; f < 3; f++) drive_frame(1, 2, -1, 0, -1, 1'b0, 1'b0);
        bus.Vsync = 1'b1;
        model_fs();
        repeat (4) tick();
        bus.Vsync = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            bus.Href = 1'b1; bus.Data = DW'($urandom);
            tick();
        end
        checks++;
        if (bus.ImageState !== 1'b0 || bus.DataHs !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_run: got is=%b hs=%b expected 0 1", bus.ImageState, bus.DataHs);
        end
        Rst_p = 1'b1; bus.Data = DW'($urandom);
        tick();
        model_reset();
        checks++;
        if ({bus.ImageState, bus.DataValid, bus.DataHs, bus.DataVs, bus.FrameDone, bus.PartialErr,
             bus.DataPixel, bus.Xaddr, bus.Yaddr} !== {1'b1, (EW + 5)'(0)}) begin
            errors++;
            $display("FAIL rst_midline_outputs: got %h expected %h",
                {bus.ImageState, bus.DataValid, bus.DataHs, bus.DataVs, bus.FrameDone, bus.PartialErr,
                 bus.DataPixel, bus.Xaddr, bus.Yaddr}, {1'b1, (EW + 5)'(0)});
        end
        Rst_p = 1'b0;
        clear_q();
        for (int k = 0; k < 3; k++) begin
            bus.Data = DW'($urandom);
            tick();
        end
        bus.Href = 1'b0;
        repeat (3) tick();
        checks++;
        if (got_q.size() != 0 || bus.ImageState !== 1'b1) begin
            errors++;
            $display("FAIL rst_no_output: got %0d strobes is=%b expected 0 1", got_q.size(), bus.ImageState);
        end
        fd_cnt = 0; fd_exp = 0;
        for (int f = 0; f < 3; f++) drive_frame(2, 3, -1, 0, -1, 1'b0, 1'b0);
        drive_frame(0, 0, -1, 0, -1, 1'b0, 1'b0);
        checks++;
        if (got_q.size() != 6 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_resume_count: got %0d expected 6", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_resume_pixel i%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (fd_cnt != 1 || fd_exp != 1) begin
            errors++;
            $display("FAIL rst_resume_framedone: got %0d expected 1", fd_cnt);
        end
    endtask

    initial begin
        fixed_b[0] = 8'hAB;
        fixed_b[1] = 8'hCD;
        test_reset();
        test_skip();
        test_latency();
        test_window();
        test_random();
        test_partial();
        test_enable_drop();
        test_rst_midline();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
